// File: rtl/rgb_colour_sequencer.sv
// rgb_colour_sequencer
//   Upstream stage of the lighting datapath. Steps a 3-bit colour index
//   through the fixed cycle 001 -> 010 -> 011 -> 100 -> 101 -> 110 -> 001.
//   A step is requested by a button rising edge or by the auto-mode
//   prescaler tick. The index is decoded to a registered 24-bit RGB word.
//
// Parameters
//   PRESCALE   clock cycles between automatic steps (legal 2..65535)
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset, highest priority
//   enable     low freezes stepping; outputs hold
//   button     step request, already synchronous; rising edge = one step
//   auto_mode  high lets the prescaler generate periodic step requests
//   colour     registered colour index {R,G,B}
//   rgb        registered decoded colour {R[7:0],G[7:0],B[7:0]}
//   step_pulse one-cycle strobe in the cycle a new colour first appears
module rgb_colour_sequencer #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        button,
    input  logic        auto_mode,
    output logic [2:0]  colour,
    output logic [23:0] rgb,
    output logic        step_pulse
);

    localparam logic [15:0] TICK_AT = 16'(PRESCALE - 32'd1);

    logic        button_q_r;
    logic [15:0] count_r;
    logic [2:0]  colour_r;
    logic [23:0] rgb_r;
    logic        step_pulse_r;

    logic        btn_edge_s;
    logic        auto_tick_s;
    logic        step_s;
    logic        counting_s;
    logic [2:0]  next_colour_s;
    logic [23:0] next_rgb_s;

    // Step request generation: a coincident edge and tick still give one step.
    always_comb begin
        btn_edge_s  = button & ~button_q_r;
        auto_tick_s = (count_r == TICK_AT);
        counting_s  = enable & auto_mode;
        step_s      = enable & (btn_edge_s | auto_tick_s);
    end

    // Next colour in the six-colour cycle; 000 and 111 both enter at 001.
    always_comb begin
        next_colour_s = 3'b001;
        case (colour_r)
            3'b000:  next_colour_s = 3'b001;
            3'b001:  next_colour_s = 3'b010;
            3'b010:  next_colour_s = 3'b011;
            3'b011:  next_colour_s = 3'b100;
            3'b100:  next_colour_s = 3'b101;
            3'b101:  next_colour_s = 3'b110;
            3'b110:  next_colour_s = 3'b001;
            default: next_colour_s = 3'b001;
        endcase
    end

    // Decode each index bit to a full-scale 8-bit channel.
    always_comb begin
        next_rgb_s = {{8{next_colour_s[2]}}, {8{next_colour_s[1]}}, {8{next_colour_s[0]}}};
    end

    // Button history tracks every cycle so edges seen while disabled are lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            button_q_r <= 1'b0;
        end else begin
            button_q_r <= button;
        end
    end

    // Prescaler: counts only while enabled in auto mode, otherwise parked at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 16'd0;
        end else if (!counting_s) begin
            count_r <= 16'd0;
        end else if (auto_tick_s) begin
            count_r <= 16'd0;
        end else begin
            count_r <= count_r + 16'd1;
        end
    end

    // Colour state, decoded word and strobe all update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            colour_r     <= 3'b000;
            rgb_r        <= 24'h000000;
            step_pulse_r <= 1'b0;
        end else if (step_s) begin
            colour_r     <= next_colour_s;
            rgb_r        <= next_rgb_s;
            step_pulse_r <= 1'b1;
        end else begin
            colour_r     <= colour_r;
            rgb_r        <= rgb_r;
            step_pulse_r <= 1'b0;
        end
    end

    assign colour     = colour_r;
    assign rgb        = rgb_r;
    assign step_pulse = step_pulse_r;

endmodule

// File: tb/tb_rgb_colour_sequencer.sv
// Testbench for rgb_colour_sequencer: directed scenarios followed by random
// stimulus. A per-cycle reference model predicts the outputs after each edge
// and queues them; an independent monitor pops and compares after each edge.
module tb_rgb_colour_sequencer;

    localparam int PRESCALE = 4;

    typedef struct packed {
        logic [2:0]  c;
        logic [23:0] rgb;
        logic        sp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        button;
    logic        auto_mode;
    logic [2:0]  colour;
    logic [23:0] rgb;
    logic        step_pulse;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;

    // Reference model state, expressed as plain integers and lookup tables.
    int   m_colour;
    int   m_count;
    bit   m_btn_q;
    logic [23:0] rgb_tab [8];
    int   nxt_tab [8];

    rgb_colour_sequencer #(.PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .button     (button),
        .auto_mode  (auto_mode),
        .colour     (colour),
        .rgb        (rgb),
        .step_pulse (step_pulse)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock edge with the given inputs; queue the result.
    task automatic model_edge(input bit r, input bit en, input bit b, input bit am);
        bit   edge_seen;
        bit   tick;
        bit   stp;
        exp_t e;
        if (r) begin
            m_colour = 0;
            m_count  = 0;
            m_btn_q  = 1'b0;
            stp      = 1'b0;
        end else begin
            edge_seen = b && !m_btn_q;
            tick      = (m_count == PRESCALE - 1);
            stp       = en && (edge_seen || tick);
            if (en && am) m_count = tick ? 0 : m_count + 1;
            else          m_count = 0;
            m_btn_q = b;
            if (stp) m_colour = nxt_tab[m_colour];
        end
        e.c   = 3'(m_colour);
        e.rgb = rgb_tab[m_colour];
        e.sp  = stp;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs away from the rising edge and predict its effect.
    task automatic drive(input bit r, input bit en, input bit b, input bit am);
        @(negedge clk);
        rst       = r;
        enable    = en;
        button    = b;
        auto_mode = am;
        model_edge(r, en, b, am);
    endtask

    // Monitor: after each rising edge compare the DUT against the oldest prediction.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (colour !== mon_e.c) begin
                failures++;
                $display("FAIL colour t=%0t actual=%b required=%b", $time, colour, mon_e.c);
            end
            checks++;
            if (rgb !== mon_e.rgb) begin
                failures++;
                $display("FAIL rgb t=%0t actual=%h required=%h", $time, rgb, mon_e.rgb);
            end
            checks++;
            if (step_pulse !== mon_e.sp) begin
                failures++;
                $display("FAIL step_pulse t=%0t actual=%b required=%b", $time, step_pulse, mon_e.sp);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        int guard;
        checks   = 0;
        failures = 0;
        m_colour = 0;
        m_count  = 0;
        m_btn_q  = 1'b0;
        rgb_tab  = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                     24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        nxt_tab  = '{1, 2, 3, 4, 5, 6, 1, 1};
        rst = 1'b1; enable = 1'b0; button = 1'b0; auto_mode = 1'b0;

        // Reset then idle.
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Manual stepping: 8 single-cycle pulses spaced 3 cycles apart.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Held button gives one step; a fresh press gives one more.
        repeat (10) drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2)  drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3)  drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2)  drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Auto mode from reset release, then drop auto_mode for 2 cycles.
        repeat (2)  drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2)  drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (9)  drive(1'b0, 1'b1, 1'b0, 1'b1);

        // Coincident button edge and auto tick must advance only once.
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, (m_count == PRESCALE - 1), 1'b1);

        // Enable low with button pulses and auto mode: nothing may change.
        for (int i = 0; i < 12; i++)
            drive(1'b0, 1'b0, i[0], 1'b1);

        // Button held across the enable rise gives no step.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the cycle an auto step would occur.
        guard = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        while (m_count != PRESCALE - 1 && guard < 16) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            guard++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Button held through reset release yields exactly one step.
        repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 1), ($urandom_range(0, 3) != 0));

        // Drain the scoreboard and make sure every prediction was consumed.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
